// File: rtl/instruction_fetch_sequencer_if.sv
// Handshake bundle between the fetch sequencer, the control unit, byte-wide memory and the IR.
// master = control/memory side, slave = the sequencer itself.
interface instruction_fetch_sequencer_if #(
    parameter int ADDR_WIDTH = 16
);
    logic                  Start;
    logic [ADDR_WIDTH-1:0] Addr;
    logic [ADDR_WIDTH-1:0] MemAddr;
    logic                  MemRead;
    logic                  MemReady;
    logic [7:0]            MemData;
    logic                  IRWrite;
    logic                  IRLH;
    logic [7:0]            IRByte;
    logic                  Busy;
    logic                  Done;
    logic                  Error;

    modport master (
        output Start, Addr, MemReady, MemData,
        input  MemAddr, MemRead, IRWrite, IRLH, IRByte, Busy, Done, Error
    );

    modport slave (
        input  Start, Addr, MemReady, MemData,
        output MemAddr, MemRead, IRWrite, IRLH, IRByte, Busy, Done, Error
    );
endinterface

// File: rtl/instruction_fetch_sequencer.sv
// Two-byte little-endian instruction fetch into the 16-bit IR over a byte-wide memory handshake.
// Optional per-byte wait timeout enabled by defining FETCH_TIMEOUT_EN.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for Start, captures Addr on acceptance
// REQ_LO  | MemRead at Addr, waiting for MemReady
// LOAD_LO | IRWrite of low byte (IRLH=0)
// REQ_HI  | MemRead at Addr+1, waiting for MemReady
// LOAD_HI | IRWrite of high byte (IRLH=1)
// DONE    | one-cycle Done pulse, Busy still high
module instruction_fetch_sequencer #(
    parameter int ADDR_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                          Clock,
    input  logic                          ResetN,
    instruction_fetch_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ_LO  = 3'd1,
        LOAD_LO = 3'd2,
        REQ_HI  = 3'd3,
        LOAD_HI = 3'd4,
        DONE    = 3'd5
    } state_t;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] memaddr;
    logic                  memread;
    logic                  irwrite;
    logic                  irlh;
    logic [7:0]            irbyte;
    logic                  busy;
    logic                  done;

`ifdef FETCH_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    // Down-counter reloaded on entry to each REQ state; abort when it is already at zero.
    localparam logic [CW-1:0] WAIT_LOAD = CW'(TIMEOUT_CYCLES - 1);

    logic          error;
    logic [CW-1:0] waitcnt;
`endif

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state   <= IDLE;
            addr    <= '0;
            memaddr <= '0;
            memread <= 1'b0;
            irwrite <= 1'b0;
            irlh    <= 1'b0;
            irbyte  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            error   <= 1'b0;
            waitcnt <= '0;
`endif
        end else begin
            irwrite <= 1'b0;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.Start) begin
                        addr    <= bus.Addr;
                        memaddr <= bus.Addr;
                        memread <= 1'b1;
                        busy    <= 1'b1;
                        state   <= REQ_LO;
`ifdef FETCH_TIMEOUT_EN
                        error   <= 1'b0;
                        waitcnt <= WAIT_LOAD;
`endif
                    end
                end

                REQ_LO: begin
                    if (bus.MemReady) begin
                        irbyte  <= bus.MemData;
                        irlh    <= 1'b0;
                        irwrite <= 1'b1;
                        memread <= 1'b0;
                        state   <= LOAD_LO;
                    end
`ifdef FETCH_TIMEOUT_EN
                    else if (waitcnt == '0) begin
                        memread <= 1'b0;
                        busy    <= 1'b0;
                        error   <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        waitcnt <= waitcnt - 1'b1;
                    end
`endif
                end

                LOAD_LO: begin
                    // Addr+1 wraps naturally at the register width.
                    memaddr <= addr + 1'b1;
                    memread <= 1'b1;
                    state   <= REQ_HI;
`ifdef FETCH_TIMEOUT_EN
                    waitcnt <= WAIT_LOAD;
`endif
                end

                REQ_HI: begin
                    if (bus.MemReady) begin
                        irbyte  <= bus.MemData;
                        irlh    <= 1'b1;
                        irwrite <= 1'b1;
                        memread <= 1'b0;
                        state   <= LOAD_HI;
                    end
`ifdef FETCH_TIMEOUT_EN
                    else if (waitcnt == '0) begin
                        memread <= 1'b0;
                        busy    <= 1'b0;
                        error   <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        waitcnt <= waitcnt - 1'b1;
                    end
`endif
                end

                LOAD_HI: begin
                    done  <= 1'b1;
                    state <= DONE;
                end

                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    memread <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.MemAddr = memaddr;
    assign bus.MemRead = memread;
    assign bus.IRWrite = irwrite;
    assign bus.IRLH    = irlh;
    assign bus.IRByte  = irbyte;
    assign bus.Busy    = busy;
    assign bus.Done    = done;
`ifdef FETCH_TIMEOUT_EN
    assign bus.Error   = error;
`else
    assign bus.Error   = 1'b0;
`endif
endmodule

// File: tb/tb_instruction_fetch_sequencer.sv
// Randomized bench for instruction_fetch_sequencer against a transaction-level fetch model.
`timescale 1ns/1ps
module tb_instruction_fetch_sequencer;
    localparam int AW = 16;
    localparam int TO = 4;

    logic Clock = 1'b0;
    logic ResetN;

    instruction_fetch_sequencer_if #(.ADDR_WIDTH(AW)) bus ();

    instruction_fetch_sequencer #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .Clock  (Clock),
        .ResetN (ResetN),
        .bus    (bus)
    );

    always #5 Clock = ~Clock;

    int total = 0;
    int bad   = 0;
    logic [7:0] mem [logic [15:0]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] mem_at(input logic [15:0] a);
        if (!mem.exists(a)) mem[a] = 8'($urandom);
        return mem[a];
    endfunction

    // One fetch from Addr=a; memory answers after dl/dh idle REQ cycles.
    // Model: Done lands at 5+dl+dh cycles after Start; IR = {mem[a+1], mem[a]}.
    task automatic fetch(input logic [15:0] a, input int dl, input int dh, input bit noise,
                         input bit chain, input int rst_k, input bit to_mode);
        logic [15:0] ahi;
        logic [7:0]  wbyte [2];
        logic        wlh [2];
        int nwr, ndone, done_k, end_k, waited, want, bound;
        ahi      = a + 16'd1;
        wbyte[0] = 8'h00; wbyte[1] = 8'h00;
        wlh[0]   = 1'b1;  wlh[1]   = 1'b0;
        nwr = 0; ndone = 0; done_k = -1; end_k = -1; waited = 0;
        bound = to_mode ? (25 + dl + TO) : (25 + dl + dh);
        bus.Start = 1'b1;
        bus.Addr  = a;
        for (int k = 1; k <= bound; k++) begin
            @(negedge Clock);
            if (to_mode && !bus.Busy) begin
                end_k = k;
                break;
            end
            if (bus.IRWrite) begin
                chk("rd_with_wr", 32'(bus.MemRead), 0);
                if (nwr < 2) begin
                    wlh[nwr]   = bus.IRLH;
                    wbyte[nwr] = bus.IRByte;
                end
                nwr++;
            end
            if (bus.MemRead) chk("memaddr", 32'(bus.MemAddr), 32'((nwr == 0) ? a : ahi));
            if (!to_mode) chk("busy", 32'(bus.Busy), 1);
            chk("err_clr", 32'(bus.Error), 0);
            if (bus.Done) begin
                ndone++;
                if (done_k < 0) done_k = k;
            end
            if (k == rst_k) begin
                #2 ResetN = 1'b0;
                #1 chk("rst_outs", 32'({bus.MemAddr, bus.MemRead, bus.IRWrite, bus.IRLH,
                                        bus.IRByte, bus.Busy, bus.Done, bus.Error}), 0);
                bus.Start    = 1'b0;
                bus.MemReady = 1'b0;
                repeat (2) begin
                    @(negedge Clock);
                    chk("rst_hold", 32'({bus.IRWrite, bus.Busy, bus.MemRead}), 0);
                end
                ResetN = 1'b1;
                return;
            end
            if (bus.MemRead) begin
                want = (nwr == 0) ? dl : dh;
                if (waited == want) begin
                    bus.MemReady = 1'b1;
                    bus.MemData  = mem_at(bus.MemAddr);
                end else begin
                    bus.MemReady = 1'b0;
                    bus.MemData  = 8'($urandom);
                end
                waited++;
            end else begin
                waited       = 0;
                bus.MemReady = 1'($urandom);
                bus.MemData  = 8'($urandom);
            end
            bus.Addr  = 16'($urandom);
            bus.Start = (done_k > 0 && chain) ? 1'b1 : (noise ? 1'($urandom) : 1'b0);
            if (done_k > 0) break;
        end
        if (to_mode) begin
            chk("to_end", 32'(end_k), 32'(3 + dl + TO));
            chk("to_nwr", 32'(nwr), 1);
            chk("to_err", 32'(bus.Error), 1);
            chk("to_done", 32'(ndone), 0);
            chk("to_rd", 32'(bus.MemRead), 0);
            bus.Start = 1'b0;
            return;
        end
        chk("latency", 32'(done_k), 32'(5 + dl + dh));
        chk("nwr", 32'(nwr), 2);
        chk("lh_order", 32'({wlh[0], wlh[1]}), 32'b01);
        chk("ir", 32'({wbyte[1], wbyte[0]}), 32'({mem_at(ahi), mem_at(a)}));
        @(negedge Clock);
        chk("idle_busy", 32'(bus.Busy), 0);
        chk("done_pulse", 32'(bus.Done), 0);
        chk("idle_rd_wr", 32'({bus.MemRead, bus.IRWrite}), 0);
        chk("hold_lh", 32'(bus.IRLH), 1);
        chk("hold_byte", 32'(bus.IRByte), 32'(mem_at(ahi)));
        if (!chain) bus.Start = 1'b0;
        bus.MemReady = 1'($urandom);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no_finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ResetN       = 1'b0;
        bus.Start    = 1'b0;
        bus.Addr     = '0;
        bus.MemReady = 1'b0;
        bus.MemData  = '0;
        mem[16'h0040] = 8'h34;
        mem[16'h0041] = 8'h12;
        repeat (3) @(negedge Clock);
        chk("reset_outs", 32'({bus.MemAddr, bus.MemRead, bus.IRWrite, bus.IRLH,
                               bus.IRByte, bus.Busy, bus.Done, bus.Error}), 0);
        ResetN = 1'b1;
        @(negedge Clock);
        chk("idle_after_rst", 32'({bus.Busy, bus.MemRead}), 0);

        fetch(16'h0040, 0, 0, 1'b0, 1'b0, 0, 1'b0);
        chk("ir_hi_12", 32'(bus.IRByte), 32'h12);
        fetch(16'h1000, 3, 3, 1'b0, 1'b0, 0, 1'b0);
        fetch(16'hFFFF, 0, 1, 1'b1, 1'b0, 0, 1'b0);
        fetch(16'h0200, 0, 50, 1'b0, 1'b0, 3, 1'b0);
        fetch(16'h0200, 0, 0, 1'b0, 1'b0, 0, 1'b0);
        fetch(16'h0300, 1, 0, 1'b0, 1'b1, 0, 1'b0);
        fetch(16'h0302, 0, 2, 1'b0, 1'b1, 0, 1'b0);
        fetch(16'h0304, 0, 0, 1'b0, 1'b0, 0, 1'b0);
`ifdef FETCH_TIMEOUT_EN
        fetch(16'h0400, 1, 1000, 1'b0, 1'b0, 0, 1'b1);
        fetch(16'h0400, 0, 0, 1'b0, 1'b0, 0, 1'b0);
`endif
        for (int i = 0; i < 40; i++)
            fetch(16'($urandom), $urandom_range(0, 4), $urandom_range(0, 4),
                  1'($urandom), 1'($urandom), 0, 1'b0);
        bus.Start = 1'b0;
        repeat (10) @(negedge Clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
